// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide memory port.
// Word-crossing accesses become two aligned transactions; load data is merged and extended.
module lsu_mem_ctrl #(
    parameter bit ALLOW_MISALIGN = 1'b1,
    parameter int MAX_WAIT       = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        busy
);

    // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
    // a memory transaction completes on a rising edge with mem_valid & mem_ready.

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t         st, st_nxt;
    logic           store_q, split_q, err_q;
    logic [2:0]     f3_q;
    logic [31:0]    addr_q, wdata_q, word0_q, rdata_q;
    logic [CW-1:0]  cnt_q;

    function automatic logic [3:0] mask_of(input logic [1:0] sz);
        case (sz)
            2'b00:   mask_of = 4'b0001;
            2'b01:   mask_of = 4'b0011;
            default: mask_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Any strobe spilling into the upper nibble means the access crosses a word.
    logic [7:0]  req_lanes;
    logic        req_split, req_illegal;
    assign req_lanes   = {4'b0, mask_of(req_funct3[1:0])} << req_addr[1:0];
    assign req_split   = |req_lanes[7:4];
    assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                         (req_split && !ALLOW_MISALIGN);

    logic [7:0]  lanes;
    logic [63:0] wdata_sh, rd_pair, rd_sh;
    logic        timeout;
    assign lanes    = {4'b0, mask_of(f3_q[1:0])} << addr_q[1:0];
    assign wdata_sh = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign rd_pair  = (st == ACC1) ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
    assign rd_sh    = rd_pair >> {addr_q[1:0], 3'b000};
    assign timeout  = (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            store_q <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            word0_q <= 32'b0;
            rdata_q <= 32'b0;
            cnt_q   <= '0;
        end else begin
            st <= st_nxt;
            case (st)
                IDLE: if (req_valid) begin
                    store_q <= req_store;
                    split_q <= req_split;
                    err_q   <= req_illegal;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= 32'b0;
                    cnt_q   <= '0;
                end
                ACC0, ACC1: begin
                    if (mem_ready) begin
                        cnt_q <= '0;
                        if (st == ACC0) word0_q <= mem_rdata;
                        if ((st == ACC1 || !split_q) && !store_q)
                            rdata_q <= extend(f3_q, rd_sh[31:0]);
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        st_nxt     = st;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'b0;
        mem_we     = 1'b0;
        mem_wstrb  = 4'b0;
        mem_wdata  = 32'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'b0;
        busy       = (st != IDLE);
        case (st)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) st_nxt = req_illegal ? RESP : ACC0;
            end
            ACC0: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = store_q;
                mem_wstrb = store_q ? lanes[3:0] : 4'b0;
                mem_wdata = wdata_sh[31:0];
                if (mem_ready)    st_nxt = split_q ? ACC1 : RESP;
                else if (timeout) st_nxt = RESP;
            end
            ACC1: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem_we    = store_q;
                mem_wstrb = store_q ? lanes[7:4] : 4'b0;
                mem_wdata = wdata_sh[63:32];
                if (mem_ready || timeout) st_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = err_q ? 32'b0 : rdata_q;
                st_nxt     = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

endmodule
